// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: reads four flash bytes at successive PC values,
// steps the PC once per byte and publishes the little-endian word on o_ir.

module fetch_ctrl_lane #(
  parameter int VEC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [VEC_W-1:0] i_d,
  output logic [VEC_W-1:0] o_q
);
  logic [VEC_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module fetch_ctrl #(
  parameter int READ_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [23:0] i_pc_in,
  output logic [1:0]  o_pc_handle,
  output logic        o_flash_cs,
  output logic        o_flash_we,
  output logic        o_flash_re,
  output logic [23:0] o_flash_addr,
  input  logic [7:0]  i_flash_out,
  output logic        o_busy,
  output logic        o_ir_valid,
  output logic [31:0] o_ir
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int CW        = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_INC, S_HOLD, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [1:0]        r_pch, w_pch_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_re, w_re_nxt;
  logic [23:0]       r_addr, w_addr_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_valid, w_valid_nxt;
  logic [31:0]       r_ir, w_ir_nxt;
  logic [NUM_LANES-1:0]            w_lane_ld;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_lane;

  // Byte lanes stay private until DONE copies them into o_ir as a whole word.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fetch_ctrl_lane #(.VEC_W(VEC_W)) u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_ld  (w_lane_ld[l]),
      .i_d   (i_flash_out),
      .o_q   (w_lane[l])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pch   <= 2'b00;
      r_cs    <= 1'b0;
      r_re    <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pch   <= w_pch_nxt;
      r_cs    <= w_cs_nxt;
      r_re    <= w_re_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_pch_nxt   = 2'b00;
    w_cs_nxt    = r_cs;
    w_re_nxt    = r_re;
    w_addr_nxt  = r_addr;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_ir_nxt    = r_ir;
    w_lane_ld   = '0;
    unique case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_ADDR;
        w_busy_nxt  = 1'b1;
        w_idx_nxt   = '0;
      end
      S_ADDR: begin
        w_addr_nxt  = i_pc_in;
        w_cs_nxt    = 1'b1;
        w_re_nxt    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      // flash_out is valid by the edge that ends the last wait cycle
      S_WAIT: if (r_cnt == CW'(READ_LAT - 1)) begin
        w_lane_ld[r_idx] = 1'b1;
        w_state_nxt      = S_CAPT;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      S_CAPT: begin
        w_cs_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_pch_nxt   = 2'b01;
        w_state_nxt = S_INC;
      end
      S_INC: w_state_nxt = S_HOLD;
      S_HOLD: if (r_idx == 2'd3) begin
        w_state_nxt = S_DONE;
      end else begin
        w_idx_nxt   = r_idx + 2'd1;
        w_state_nxt = S_ADDR;
      end
      S_DONE: begin
        w_ir_nxt    = w_lane;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort drops the bus at once; PC steps already issued stay issued.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_pch_nxt   = 2'b00;
      w_cs_nxt    = 1'b0;
      w_re_nxt    = 1'b0;
      w_addr_nxt  = '0;
      w_busy_nxt  = 1'b0;
      w_valid_nxt = 1'b0;
      w_ir_nxt    = r_ir;
      w_lane_ld   = '0;
    end
  end

  assign o_pc_handle  = r_pch;
  assign o_flash_cs   = r_cs;
  assign o_flash_we   = 1'b0;
  assign o_flash_re   = r_re;
  assign o_flash_addr = r_addr;
  assign o_busy       = r_busy;
  assign o_ir_valid   = r_valid;
  assign o_ir         = r_ir;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two builds (READ_LAT 3 and 1) against a flash/PC model,
// expected words and timing computed from memory contents and the cycle budget.
module tb_fetch_ctrl;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start[N], abort[N];
  logic [23:0] pc[N];
  logic        pc_ld[N];
  logic [23:0] pc_ld_val[N];
  logic [1:0]  pch[N];
  logic        cs[N], we[N], re[N], busy[N], irv[N];
  logic [23:0] faddr[N];
  logic [7:0]  fout[N];
  logic [31:0] ir[N];
  logic [7:0]  mem[256];
  int          lat[N];
  int          cyc = 0;
  int          inc_cnt[N], val_cnt[N], cs_cnt[N], bad_cnt[N], addr_n[N];
  logic        cs_d[N];
  logic [23:0] addr_d[N];
  logic [23:0] addr_log[N][64];
  int          checks = 0;
  int          failures = 0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    fetch_ctrl #(.READ_LAT((g == 0) ? 3 : 1)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start[g]),
      .i_abort      (abort[g]),
      .i_pc_in      (pc[g]),
      .o_pc_handle  (pch[g]),
      .o_flash_cs   (cs[g]),
      .o_flash_we   (we[g]),
      .o_flash_re   (re[g]),
      .o_flash_addr (faddr[g]),
      .i_flash_out  (fout[g]),
      .o_busy       (busy[g]),
      .o_ir_valid   (irv[g]),
      .o_ir         (ir[g])
    );
  end

  function automatic int rl(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // PC register and flash latency tracking
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (rst) pc[k] <= '0;
      else if (pc_ld[k]) pc[k] <= pc_ld_val[k];
      else if (pch[k] == 2'b01) pc[k] <= pc[k] + 24'd1;
      lat[k] <= (cs[k] && re[k]) ? lat[k] + 1 : 0;
    end
  end

  // Flash returns garbage until READ_LAT cycles of presented address have passed
  always_comb begin
    for (int k = 0; k < N; k++)
      fout[k] = (cs[k] && re[k] && lat[k] >= rl(k) - 1) ? mem[faddr[k][7:0]] : ~mem[faddr[k][7:0]];
  end

  // Per-cycle monitor: counts the cycle that the edge closes
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (pch[k] == 2'b01) inc_cnt[k]++;
      if (pch[k][1] || we[k] || (cs[k] != re[k])) bad_cnt[k]++;
      if (irv[k]) val_cnt[k]++;
      if (cs[k] && re[k]) cs_cnt[k]++;
      if (cs[k] && !cs_d[k]) begin
        addr_log[k][addr_n[k] % 64] = faddr[k];
        addr_n[k]++;
      end
      if (cs[k] && cs_d[k] && faddr[k] != addr_d[k]) bad_cnt[k]++;
      cs_d[k]   = cs[k];
      addr_d[k] = faddr[k];
    end
  end

  task automatic set_pc(input int k, input logic [23:0] v);
    pc_ld_val[k] = v;
    pc_ld[k] = 1'b1;
    @(negedge clk);
    pc_ld[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      got = {pch[k], cs[k], we[k], re[k], faddr[k], busy[k], irv[k], ir[k]};
      checks++;
      if (got !== 64'h0) begin
        failures++;
        $display("FAIL reset_outputs k=%0d got=%h want=0", k, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete fetch checked against the memory model; returns at the ir_valid cycle.
  task automatic run_fetch(input int k, input bit hold, input bit with_abort);
    logic [23:0] p0, a;
    logic [31:0] exp_ir, ir0;
    int i0, c0, n0, e0, n;
    bit part;
    p0 = pc[k];
    ir0 = ir[k];
    for (int i = 0; i < 4; i++) begin
      a = p0 + 24'(i);
      exp_ir[8*i +: 8] = mem[a[7:0]];
    end
    i0 = inc_cnt[k]; c0 = cs_cnt[k]; n0 = addr_n[k];
    start[k] = 1'b1;
    abort[k] = with_abort;
    @(negedge clk);
    e0 = cyc;
    if (!hold) start[k] = 1'b0;
    abort[k] = 1'b0;
    checks++;
    if (busy[k] !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start k=%0d got=%b want=1", k, busy[k]);
    end
    n = 0; part = 0;
    while (irv[k] !== 1'b1 && n < 200) begin
      if (ir[k] !== ir0) part = 1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - e0 != 4 * (rl(k) + 4) + 1) begin
      failures++;
      $display("FAIL ir_valid_latency k=%0d got=%0d want=%0d", k, cyc - e0, 4 * (rl(k) + 4) + 1);
    end
    checks++;
    if (ir[k] !== exp_ir) begin
      failures++;
      $display("FAIL ir_word k=%0d pc0=%h got=%h want=%h", k, p0, ir[k], exp_ir);
    end
    checks++;
    if (part) begin
      failures++;
      $display("FAIL ir_partial k=%0d got=changed want=held before ir_valid", k);
    end
    checks++;
    if (pc[k] !== p0 + 24'd4) begin
      failures++;
      $display("FAIL pc_after k=%0d got=%h want=%h", k, pc[k], p0 + 24'd4);
    end
    checks++;
    if (inc_cnt[k] - i0 != 4) begin
      failures++;
      $display("FAIL inc_pulses k=%0d got=%0d want=4", k, inc_cnt[k] - i0);
    end
    checks++;
    if (cs_cnt[k] - c0 != 4 * (rl(k) + 1)) begin
      failures++;
      $display("FAIL cs_cycles k=%0d got=%0d want=%0d", k, cs_cnt[k] - c0, 4 * (rl(k) + 1));
    end
    checks++;
    if (addr_n[k] - n0 != 4) begin
      failures++;
      $display("FAIL addr_count k=%0d got=%0d want=4", k, addr_n[k] - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[k][(n0 + i) % 64] !== p0 + 24'(i)) begin
          failures++;
          $display("FAIL flash_addr k=%0d byte=%0d got=%h want=%h", k, i, addr_log[k][(n0 + i) % 64], p0 + 24'(i));
        end
      end
    end
    checks++;
    if (busy[k] !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_valid k=%0d got=%b want=0", k, busy[k]);
    end
  endtask

  task automatic test_basic();
    run_fetch(0, 0, 0);
    checks++;
    if (ir[0] !== 32'h02000283) begin
      failures++;
      $display("FAIL basic_word got=%h want=02000283", ir[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_fetch(0, 0, 0);
    checks++;
    if (ir[0] !== 32'h02100303 || pc[0] !== 24'd8) begin
      failures++;
      $display("FAIL b2b_word got=%h/pc=%h want=02100303/pc=000008", ir[0], pc[0]);
    end
  endtask

  task automatic test_hold_start();
    int i0;
    run_fetch(0, 1, 0);
    run_fetch(0, 0, 0);
    i0 = inc_cnt[0];
    repeat (20) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || inc_cnt[0] != i0) begin
      failures++;
      $display("FAIL hold_extra_fetch got=busy%b/inc%0d want=busy0/inc0", busy[0], inc_cnt[0] - i0);
    end
  endtask

  task automatic test_abort();
    logic [23:0] p0;
    logic [31:0] ir0;
    logic [31:0] got;
    int v0, i0;
    p0 = pc[0]; ir0 = ir[0]; v0 = val_cnt[0]; i0 = inc_cnt[0];
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (cs[0] !== 1'b1 || faddr[0] !== p0 + 24'd2) begin
      failures++;
      $display("FAIL abort_setup got=cs%b/addr%h want=cs1/addr%h", cs[0], faddr[0], p0 + 24'd2);
    end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    got = {pch[0], cs[0], re[0], faddr[0], busy[0], irv[0]};
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL abort_outputs got=%h want=0", got);
    end
    checks++;
    if (pc[0] !== p0 + 24'd2) begin
      failures++;
      $display("FAIL abort_pc got=%h want=%h", pc[0], p0 + 24'd2);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (ir[0] !== ir0 || val_cnt[0] != v0 || busy[0] !== 1'b0 || inc_cnt[0] - i0 != 2) begin
      failures++;
      $display("FAIL abort_after got=ir%h/val%0d/busy%b/inc%0d want=ir%h/val0/busy0/inc2",
               ir[0], val_cnt[0] - v0, busy[0], inc_cnt[0] - i0, ir0);
    end
  endtask

  task automatic test_idle_abort();
    abort[0] = 1'b1;
    repeat (3) @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || cs[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort got=busy%b/cs%b want=busy0/cs0", busy[0], cs[0]);
    end
    run_fetch(0, 0, 1);
  endtask

  task automatic test_wrap();
    set_pc(0, 24'hFFFFFE);
    run_fetch(0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      set_pc(0, 24'($urandom));
      run_fetch(0, 0, 0);
      if (t[0]) run_fetch(0, 0, 0);
    end
  endtask

  task automatic test_rst_mid();
    logic [63:0] got;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pch[0] !== 2'b01) begin
      failures++;
      $display("FAIL inc_position got=%b want=01", pch[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {pch[0], cs[0], we[0], re[0], faddr[0], busy[0], irv[0], ir[0]};
    checks++;
    if (got !== 64'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h want=0", got);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || cs[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_restart got=busy%b/cs%b want=busy0/cs0", busy[0], cs[0]);
    end
  endtask

  task automatic test_lat1();
    set_pc(1, 24'h000008);
    run_fetch(1, 0, 0);
    checks++;
    if (ir[1] !== 32'h006283b3) begin
      failures++;
      $display("FAIL lat1_word got=%h want=006283b3", ir[1]);
    end
  endtask

  task automatic test_invariants();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (bad_cnt[k] != 0) begin
        failures++;
        $display("FAIL bus_invariants k=%0d got=%0d violations want=0", k, bad_cnt[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; pc_ld[k] = 1'b0; pc_ld_val[k] = '0;
      inc_cnt[k] = 0; val_cnt[k] = 0; cs_cnt[k] = 0; bad_cnt[k] = 0; addr_n[k] = 0;
      cs_d[k] = 1'b0; addr_d[k] = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h83; mem[1] = 8'h02; mem[2]  = 8'h00; mem[3]  = 8'h02;
    mem[4] = 8'h03; mem[5] = 8'h03; mem[6]  = 8'h10; mem[7]  = 8'h02;
    mem[8] = 8'hb3; mem[9] = 8'h83; mem[10] = 8'h62; mem[11] = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_start();
    test_abort();
    test_idle_abort();
    test_wrap();
    test_random();
    test_rst_mid();
    test_lat1();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
